// File: rtl/hash_job_sequencer_if.sv
// Worker job bus between hash_job_sequencer (master) and one SHA-256 worker (slave).
// Handshake: while w_start=1 the worker is parked; when it falls, the worker runs on the stable
// w_* data, and a one-cycle w_finish=1 qualifies w_ho and completes that run.
interface hash_job_sequencer_if;
  logic                 w_start;
  logic                 w_phase_sel;
  logic [3:0]           w_nonce;
  logic [7:0][31:0]     w_hi;
  logic [2:0][31:0]     w_msg_tail;
  logic [7:0][31:0]     w_ho;
  logic                 w_finish;

  modport master (
    output w_start, w_phase_sel, w_nonce, w_hi, w_msg_tail,
    input  w_ho, w_finish
  );

  modport slave (
    input  w_start, w_phase_sel, w_nonce, w_hi, w_msg_tail,
    output w_ho, w_finish
  );
endinterface

// File: rtl/hash_job_sequencer.sv
// Runs phase-2 then phase-3 worker jobs per nonce and writes digest word 0 to output_addr+nonce.
// Optional worker watchdog enabled by defining SEQ_WATCHDOG_EN.
module hash_job_sequencer #(
  parameter int NUM_NONCES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0][31:0]      midstate,
  input  logic [2:0][31:0]      msg_tail,
  input  logic [15:0]           output_addr,
  output logic                  done,
  output logic                  error,
  output logic                  mem_we,
  output logic [15:0]           mem_addr,
  output logic [31:0]           mem_write_data,
  hash_job_sequencer_if.master  wk,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH2 = 3'd1,
    WAIT2   = 3'd2,
    LAUNCH3 = 3'd3,
    WAIT3   = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [3:0] LAST_NONCE = 4'(NUM_NONCES - 1);

  if (NUM_NONCES < 1 || NUM_NONCES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("hash_job_sequencer: illegal NUM_NONCES or TIMEOUT_CYCLES");
  end

  state_t             state_q, state_d;
  logic [3:0]         nonce_q;
  logic [7:0][31:0]   midstate_q;
  logic [2:0][31:0]   msg_tail_q;
  logic [15:0]        addr_q;
  logic [7:0][31:0]   p2_q;
  logic [31:0]        result_q;
  logic               error_q;

  logic               load_job;
  logic               cap_p2;
  logic               cap_res;
  logic               inc_nonce;
  logic               timeout;
  logic               wd_expired;
  logic               waiting;

  assign waiting = (state_q == WAIT2) || (state_q == WAIT3);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    load_job  = 1'b0;
    cap_p2    = 1'b0;
    cap_res   = 1'b0;
    inc_nonce = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_job = 1'b1;
          state_d  = LAUNCH2;
        end
      end
      LAUNCH2: state_d = WAIT2;
      WAIT2: begin
        if (wk.w_finish) begin
          cap_p2  = 1'b1;
          state_d = LAUNCH3;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      LAUNCH3: state_d = WAIT3;
      WAIT3: begin
        if (wk.w_finish) begin
          cap_res = 1'b1;
          state_d = WRITE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (nonce_q == LAST_NONCE) begin
          state_d = DONE;
        end else begin
          inc_nonce = 1'b1;
          state_d   = LAUNCH2;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nonce_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (load_job) begin
        nonce_q <= 4'd0;
      end else if (inc_nonce) begin
        nonce_q <= nonce_q + 4'd1;
      end
    end
  end

  // Job data needs no reset: it is only consumed after a start has loaded it.
  always_ff @(posedge clk) begin
    if (load_job) begin
      midstate_q <= midstate;
      msg_tail_q <= msg_tail;
      addr_q     <= output_addr;
    end
    if (cap_p2) begin
      p2_q <= wk.w_ho;
    end
    if (cap_res) begin
      result_q <= wk.w_ho[0];
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WD_W-1:0] wd_q;

  // LAUNCH states always precede a WAIT state, so clearing there clears on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || !waiting) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (load_job) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign error_q    = 1'b0;
`endif

  // Moore outputs
  assign wk.w_start      = !waiting;
  assign wk.w_phase_sel  = (state_q == LAUNCH3) || (state_q == WAIT3);
  assign wk.w_hi         = wk.w_phase_sel ? p2_q : midstate_q;
  assign wk.w_nonce      = nonce_q;
  assign wk.w_msg_tail   = msg_tail_q;

  assign mem_we          = (state_q == WRITE);
  assign mem_addr        = addr_q + 16'(nonce_q);
  assign mem_write_data  = result_q;
  assign done            = (state_q == DONE);
  assign error           = error_q;
  assign dbg_state       = state_q;

endmodule
